multiplier32_seq: RTL and testbench



---
 rtl/multiplier32_seq.sv | 139 +++++++++++++
 tb/tb_multiplier32_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplier32_seq.sv
// multiplier32_seq: iterative unsigned shift-add multiplier.
//
// Produces the full 2*WIDTH-bit product of two WIDTH-bit operands using a
// single 2*WIDTH-bit adder, one multiplier bit per clock. Control is a small
// IDLE -> CALC -> DONE machine driven through a start/done handshake.
//
// Optional build macro: MUL_EARLY_EXIT_EN
//   When defined, CALC also ends as soon as the remaining multiplier bits are
//   all zero, so short multipliers finish early. The product value is the same
//   in both builds; only the latency differs.

`default_nettype none

module multiplier32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;

    logic [2*WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     b_shift;
    logic                 last_iter;

    // The one adder: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        addend  = b_reg[0] ? a_reg : '0;
        acc_sum = acc + addend;
        b_shift = b_reg >> 1;
    end

    // Decide whether the current CALC cycle is the final one.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        last_iter = (cnt == LAST_CNT) || (b_shift == '0);
`else
        last_iter = (cnt == LAST_CNT);
`endif
    end

    // State register; reset drops straight back to IDLE, aborting any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the Moore handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on an accepted start, then shift and accumulate
    // once per CALC cycle. The product register is only written on the way into
    // DONE, so it holds the previous result for the whole of a new operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= {{WIDTH{1'b0}}, a};
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_CALC: begin
                    acc   <= acc_sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_shift;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier32_seq.sv
// tb_multiplier32_seq: table-driven bench for multiplier32_seq, plus hand-written
// sequences for reset, ignored start, mid-operation reset and back-to-back starts.

`timescale 1ns/1ps

module tb_multiplier32_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          glitch_at;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_applied;
    int n_miss;

    vec_t vecs [12];

    multiplier32_seq #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of CALC cycles the multiplier should spend on multiplier value bv.
    function automatic int calcCycles(input logic [31:0] bv);
        int n;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int k = 0; k < 32; k++) begin
            if (bv[k]) n = k + 1;
        end
`else
        n = 32;
        if (bv === 32'hx) n = 0;
`endif
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one operation starting at a negedge with the DUT idle. Returns the
    // product seen on done, the cycle number of done (start cycle = 1) and the
    // number of busy cycles. Operands are scrambled after acceptance, and an
    // optional stray start pulse is injected at cycle glitch_at.
    task automatic applyStimulus(input vec_t v, input logic [63:0] prev_prod, input string tag,
                                 output logic [63:0] prod, output int lat, output int busy_n,
                                 output bit seen);
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~v.a;
        b     = v.b ^ 32'h5A5A_5A5A;
        lat    = 1;
        busy_n = 0;
        seen   = 1'b0;
        prod   = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (lat == 2) checkOutput({tag, "/hold_old"}, product, prev_prod);
            if (done) begin
                seen = 1'b1;
                prod = product;
            end
            if (lat == v.glitch_at) begin
                start = 1'b1;
                a     = 32'd7;
                b     = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] prev_prod;
        logic [63:0] got;
        int          lat;
        int          busy_n;
        bit          seen;
        int          done_cnt;
        int          done_at [3];
        int          k;
        int          cyc;
        string       tag;

        n_applied = 0;
        n_miss    = 0;

        vecs[0]  = '{32'd12345,      32'd6789,       64'd83810205,            0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0};
        vecs[2]  = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 0};
        vecs[3]  = '{32'd0,          32'hDEAD_BEEF,  64'd0,                   0};
        vecs[4]  = '{32'hDEAD_BEEF,  32'd0,          64'd0,                   0};
        vecs[5]  = '{32'h0000_1234,  32'd1,          64'h0000_0000_0000_1234, 0};
        vecs[6]  = '{32'd3,          32'h8000_0000,  64'h0000_0001_8000_0000, 0};
        vecs[7]  = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 0};
        vecs[9]  = '{32'd12345,      32'd6789,       64'd83810205,            6};
        vecs[10] = '{32'd3,          32'd5,          64'd15,                  0};
        vecs[11] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 0};

        // Reset state, during and after reset.
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset/busy", {63'd0, busy}, 64'd0);
        checkOutput("reset/done", {63'd0, done}, 64'd0);
        checkOutput("reset/product", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset/busy", {63'd0, busy}, 64'd0);
        checkOutput("post_reset/product", product, 64'd0);

        // Vector table: value, latency, busy length, one-cycle done, held result.
        prev_prod = 64'd0;
        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i], prev_prod, tag, got, lat, busy_n, seen);
            checkOutput({tag, "/done_seen"}, {63'd0, seen}, 64'd1);
            checkOutput({tag, "/product"}, got, vecs[i].exp);
            checkOutput({tag, "/latency"}, 64'(lat), 64'(calcCycles(vecs[i].b) + 2));
            checkOutput({tag, "/busy_cycles"}, 64'(busy_n), 64'(calcCycles(vecs[i].b) + 1));
            @(negedge clk);
            checkOutput({tag, "/done_pulse_len"}, {63'd0, done}, 64'd0);
            checkOutput({tag, "/idle_busy"}, {63'd0, busy}, 64'd0);
            checkOutput({tag, "/product_held"}, product, vecs[i].exp);
            prev_prod = vecs[i].exp;
        end

        // Reset in the middle of an operation: result cleared, no done pulse.
        a     = 32'd5;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst/product", product, 64'd0);
        checkOutput("midrst/busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst/done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("midrst/no_done", 64'(done_cnt), 64'd0);
        checkOutput("midrst/product_after", product, 64'd0);

        // Start held high: back-to-back operations at a fixed period.
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        k     = 0;
        cyc   = 1;
        done_at[0] = 0;
        done_at[1] = 0;
        done_at[2] = 0;
        for (int i = 0; i < 300 && k < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                checkOutput($sformatf("b2b/product%0d", k), product, 64'd15);
                done_at[k] = cyc;
                k++;
            end
        end
        start = 1'b0;
        checkOutput("b2b/count", 64'(k), 64'd3);
        checkOutput("b2b/first_latency", 64'(done_at[0]), 64'(calcCycles(32'd5) + 2));
        checkOutput("b2b/period1", 64'(done_at[1] - done_at[0]), 64'(calcCycles(32'd5) + 2));
        checkOutput("b2b/period2", 64'(done_at[2] - done_at[1]), 64'(calcCycles(32'd5) + 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
